// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-multiply job scheduler.
package sc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    localparam logic MODE_UNI = 1'b0;   // AND gate, unipolar encoding
    localparam logic MODE_BI  = 1'b1;   // XNOR gate, bipolar encoding

    localparam int LFSR_W       = 31;
    localparam int TAP_A_HI     = 30;
    localparam int TAP_A_LO     = 27;
    localparam int TAP_B_HI     = 16;
    localparam int TAP_B_LO     = 12;
    localparam int DRAIN_CYCLES = 2;    // one per stream-unit register stage

    // Bitstream length 16 << sel, clamped to the longest supported stream.
    function automatic int unsigned len_decode(input logic [1:0] sel,
                                               input int unsigned log2_max);
        int unsigned l;
        l = 32'd4 + 32'(sel);
        if (l > log2_max) l = log2_max;
        return 32'd1 << l;
    endfunction

    // One Fibonacci shift: feedback from two taps enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input int hi,
                                                    input int lo);
        return {s[LFSR_W-2:0], s[hi] ^ s[lo]};
    endfunction

endpackage

// File: rtl/sc_job_scheduler_if.sv
// Request/result bus between requesters, result consumer and the scheduler.
interface sc_job_scheduler_if #(
    parameter int LEN_LOG2_MAX = 7
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [3:0]            req_pa0;
    logic [3:0]            req_pb0;
    logic [3:0]            req_pa1;
    logic [3:0]            req_pb1;
    logic [1:0]            req_mode;
    logic [1:0]            len_sel;
    logic                  res_valid;
    logic                  res_ready;
    logic [LEN_LOG2_MAX:0] res_count;
    logic                  res_id;

    // Requester/consumer side.
    modport master (
        output req_valid, req_pa0, req_pb0, req_pa1, req_pb1, req_mode, len_sel,
               res_ready,
        input  req_ready, res_valid, res_count, res_id
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_pa0, req_pb0, req_pa1, req_pb1, req_mode, len_sel,
               res_ready,
        output req_ready, res_valid, res_count, res_id
    );
endinterface

// File: rtl/sc_stream_unit.sv
// Shared stochastic stream unit: two LFSRs, two comparators and a mode gate,
// with a valid tag carried through two register stages.
module sc_stream_unit
    import sc_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_A = 31'd1,
    parameter logic [LFSR_W-1:0] SEED_B = 31'd2
) (
    input  logic       clk,
    input  logic       rst_n,       // synchronous, active-high
    input  logic       seed_load,
    input  logic       en,
    input  logic [3:0] pa,
    input  logic [3:0] pb,
    input  logic       mode,
    output logic       out_bit,
    output logic       out_valid
);

    logic [LFSR_W-1:0] lfsr_a;
    logic [LFSR_W-1:0] lfsr_b;
    logic              cmp_a;
    logic              cmp_b;
    logic              cmp_valid;

    // LFSRs: reload seeds on reset or job start, advance only while enabled.
    always_ff @(posedge clk) begin
        if (rst_n || seed_load) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
        end else if (en) begin
            lfsr_a <= lfsr_next(lfsr_a, TAP_A_HI, TAP_A_LO);
            lfsr_b <= lfsr_next(lfsr_b, TAP_B_HI, TAP_B_LO);
        end
    end

    // Stage 1: compare LFSR top nibbles against operands; tag bits born while enabled.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cmp_a     <= 1'b0;
            cmp_b     <= 1'b0;
            cmp_valid <= 1'b0;
        end else begin
            cmp_valid <= en;
            if (en) begin
                cmp_a <= (lfsr_a[LFSR_W-1 -: 4] < pa);
                cmp_b <= (lfsr_b[LFSR_W-1 -: 4] < pb);
            end
        end
    end

    // Stage 2: multiply gate (AND or XNOR) with the valid tag following along.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= cmp_valid;
            out_bit   <= (mode == MODE_BI) ? ~(cmp_a ^ cmp_b) : (cmp_a & cmp_b);
        end
    end

endmodule

// File: rtl/sc_job_scheduler.sv
// Round-robin job scheduler for two requesters sharing one stochastic stream
// unit; returns the ones-count of each job over a valid/ready handshake.
module sc_job_scheduler
    import sc_pkg::*;
#(
    parameter int                LEN_LOG2_MAX = 7,
    parameter logic [LFSR_W-1:0] SEED_A       = 31'd1,
    parameter logic [LFSR_W-1:0] SEED_B       = 31'd2
) (
    input  logic                clk,
    input  logic                rst_n,      // synchronous, active-high
    sc_job_scheduler_if.slave   bus,
    output logic                busy
);

    localparam int CNT_W = LEN_LOG2_MAX + 1;

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic             last_grant;
    logic             grant_id;
    logic             accept;
    logic [1:0]       req_ready_c;
    logic [CNT_W-1:0] len_n;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic [3:0]       pa_q;
    logic [3:0]       pb_q;
    logic             mode_q;
    logic             id_q;
    logic             su_bit;
    logic             su_valid;

    assign len_n = CNT_W'(len_decode(bus.len_sel, LEN_LOG2_MAX));

    // Arbiter: grant in IDLE only; on contention pick the requester not granted last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant_id    = 1'b0;
        accept      = 1'b0;
        req_ready_c = 2'b00;
        if (!rst_n && state == ST_IDLE && |bus.req_valid) begin
            accept   = 1'b1;
            grant_id = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
            req_ready_c[grant_id] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready_c;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst_n) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state: IDLE -> SEED -> RUN (N) -> DRAIN (2) -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SEED;
            ST_SEED:  state_nxt = ST_RUN;
            ST_RUN:   if (cyc_cnt == '0) state_nxt = ST_DRAIN;
            ST_DRAIN: if (cyc_cnt == '0) state_nxt = ST_DONE;
            ST_DONE:  if (bus.res_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Job latch, round-robin pointer, cycle down-counter and ones counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // NOTE: job/result registers are reset too, so res_count and res_id read 0 after reset.
            last_grant <= 1'b1;
            pa_q       <= '0;
            pb_q       <= '0;
            mode_q     <= MODE_UNI;
            id_q       <= 1'b0;
            cyc_cnt    <= '0;
            ones_cnt   <= '0;
        end else begin
            if (su_valid && su_bit) ones_cnt <= ones_cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant <= grant_id;
                        id_q       <= grant_id;
                        pa_q       <= grant_id ? bus.req_pa1 : bus.req_pa0;
                        pb_q       <= grant_id ? bus.req_pb1 : bus.req_pb0;
                        mode_q     <= bus.req_mode[grant_id];
                        cyc_cnt    <= len_n - 1'b1;
                        ones_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (cyc_cnt == '0) cyc_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                    else               cyc_cnt <= cyc_cnt - 1'b1;
                end
                ST_DRAIN: begin
                    if (cyc_cnt != '0) cyc_cnt <= cyc_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    sc_stream_unit #(
        .SEED_A (SEED_A),
        .SEED_B (SEED_B)
    ) u_stream (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (state == ST_SEED),
        .en        (state == ST_RUN),
        .pa        (pa_q),
        .pb        (pb_q),
        .mode      (mode_q),
        .out_bit   (su_bit),
        .out_valid (su_valid)
    );

    assign bus.res_valid = (state == ST_DONE);
    assign bus.res_count = ones_cnt;
    assign bus.res_id    = id_q;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_sc_job_scheduler.sv
// Scoreboard bench for sc_job_scheduler: a reference model predicts grants and
// ones-counts at accept time; a separate monitor checks each presented result.
module tb_sc_job_scheduler;

    localparam int          LEN_LOG2_MAX = 7;
    localparam logic [30:0] SEED_A       = 31'd1;
    localparam logic [30:0] SEED_B       = 31'd2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    sc_job_scheduler_if #(.LEN_LOG2_MAX(LEN_LOG2_MAX)) bus ();

    sc_job_scheduler #(
        .LEN_LOG2_MAX (LEN_LOG2_MAX),
        .SEED_A       (SEED_A),
        .SEED_B       (SEED_B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int count;
        int n;
        int acc_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         results[$];
    int         n_checks      = 0;
    int         n_pass        = 0;
    int         cyc           = 0;
    logic [1:0] accepted_mask = 2'b00;
    int         hs_count      = 0;
    int         hs_used       = 0;
    bit         model_idle    = 1'b1;
    int         last_grant    = 1;
    bit         first_seen    = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference: count ones of an N-bit product stream straight from the LFSR rules.
    function automatic int ref_count(input int pa, input int pb, input int mode, input int n);
        logic [30:0] a;
        logic [30:0] b;
        int          ones;
        bit          ba;
        bit          bb;
        a    = SEED_A;
        b    = SEED_B;
        ones = 0;
        for (int k = 0; k < n; k++) begin
            ba = int'(a[30:27]) < pa;
            bb = int'(b[30:27]) < pb;
            if ((mode != 0) ? (ba == bb) : (ba && bb)) ones++;
            a = {a[29:0], a[30] ^ a[27]};
            b = {b[29:0], b[16] ^ b[12]};
        end
        return ones;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: predicts arbitration and pushes the expected result at each accept.
    always @(negedge clk) begin
        logic [1:0] rv;
        int         g;
        int         pa;
        int         pb;
        int         md;
        int         n;
        exp_t       e;
        accepted_mask = bus.req_ready;
        if (rst_n) begin
            model_idle = 1'b1;
            last_grant = 1;
            exp_q.delete();
            hs_used    = hs_count;
        end else begin
            if (hs_count != hs_used) begin
                model_idle = 1'b1;
                hs_used    = hs_count;
            end
            check("busy", int'(busy), model_idle ? 0 : 1);
            rv = bus.req_valid;
            if (model_idle && rv != 2'b00) begin
                g = (rv == 2'b11) ? (1 - last_grant) : (rv[1] ? 1 : 0);
                check("req_ready_grant", int'(bus.req_ready), 1 << g);
                pa = (g == 1) ? int'(bus.req_pa1) : int'(bus.req_pa0);
                pb = (g == 1) ? int'(bus.req_pb1) : int'(bus.req_pb0);
                md = int'(bus.req_mode[g]);
                n  = 16 << bus.len_sel;
                e.id      = g;
                e.count   = ref_count(pa, pb, md, n);
                e.n       = n;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                last_grant = g;
                model_idle = 1'b0;
            end else begin
                check("req_ready_idle", int'(bus.req_ready), 0);
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            first_seen = 1'b0;
        end else if (bus.res_valid) begin
            check("res_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                if (!first_seen) begin
                    check("latency", cyc - exp_q[0].acc_cyc, exp_q[0].n + 4);
                    first_seen = 1'b1;
                end
                check("res_count", int'(bus.res_count), exp_q[0].count);
                check("res_id", int'(bus.res_id), exp_q[0].id);
                if (bus.res_ready) begin
                    results.push_back(int'(bus.res_count));
                    void'(exp_q.pop_front());
                    first_seen = 1'b0;
                    hs_count <= hs_count + 1;
                end
            end
        end
    end

    task automatic set_ops(input int i, input int pa, input int pb, input int mode);
        if (i == 0) begin
            bus.req_pa0 = pa[3:0];
            bus.req_pb0 = pb[3:0];
        end else begin
            bus.req_pa1 = pa[3:0];
            bus.req_pb1 = pb[3:0];
        end
        bus.req_mode[i] = mode[0];
    endtask

    // Issue one job from requester i and hold it until accepted (bounded).
    task automatic send(input int i, input int pa, input int pb, input int mode, input int ls);
        bit got;
        got = 1'b0;
        set_ops(i, pa, pb, mode);
        bus.len_sel      = ls[1:0];
        bus.req_valid[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (accepted_mask[i]) begin
                got = 1'b1;
                break;
            end
        end
        bus.req_valid[i] = 1'b0;
        bus.len_sel      = 2'($urandom_range(3));
        check("accept_wait", int'(got), 1);
    endtask

    // Wait (bounded) until every expected result has been handed over.
    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #1;
        check("drain_wait", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_count", int'(bus.res_count), 0);
        check("rst_res_id", int'(bus.res_id), 0);
        check("rst_req_ready", int'(bus.req_ready), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_acc;
        int n_acc;
        int r0;
        bit got;

        bus.req_valid = 2'b11;
        bus.req_pa0   = '0;
        bus.req_pb0   = '0;
        bus.req_pa1   = '0;
        bus.req_pb1   = '0;
        bus.req_mode  = '0;
        bus.len_sel   = '0;
        bus.res_ready = 1'b0;

        // Reset values, with requests pending that must not be granted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst_n         = 1'b0;
        bus.res_ready = 1'b1;

        // Two all-zero streams under XNOR count every bit; requester 1 AND with pa=0 counts none.
        send(0, 0, 0, 1, 0);
        wait_idle(200);
        send(1, 0, 15, 0, 3);
        wait_idle(300);

        // Continuous contention with res_ready high: alternate grants every N+5 cycles.
        set_ops(0, 3, 12, 0);
        set_ops(1, 10, 6, 1);
        bus.len_sel   = 2'd0;
        bus.req_valid = 2'b11;
        n_acc    = 0;
        prev_acc = 0;
        for (int k = 0; k < 400 && n_acc < 4; k++) begin
            @(posedge clk);
            #1;
            if (accepted_mask != 2'b00) begin
                if (n_acc > 0) check("accept_spacing", cyc - prev_acc, 16 + 5);
                prev_acc = cyc;
                n_acc++;
            end
        end
        check("alternate_accepts", n_acc, 4);
        bus.req_valid = 2'b00;
        wait_idle(200);

        // Backpressure: hold the result for 50 cycles, then release it.
        bus.res_ready = 1'b0;
        set_ops(0, 5, 11, 1);
        set_ops(1, 14, 2, 0);
        bus.req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("stall_res_wait", int'(got), 1);
        repeat (50) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (accepted_mask != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_after_stall", int'(got), 1);
        bus.req_valid = 2'b00;
        wait_idle(300);

        // Reset in the middle of RUN aborts the job; the next grant goes to requester 0.
        send(1, 7, 7, 1, 1);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_ops(0, 8, 8, 0);
        set_ops(1, 8, 8, 1);
        bus.req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (accepted_mask != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("post_reset_accept", int'(got), 1);
        bus.req_valid = 2'b00;
        wait_idle(200);

        // Reseeding makes an identical job produce an identical count.
        r0 = results.size();
        send(0, 9, 5, 0, 2);
        wait_idle(200);
        send(0, 9, 5, 0, 2);
        wait_idle(200);
        check("repeat_results", results.size() - r0, 2);
        if (results.size() >= r0 + 2) check("repeat_same", results[r0 + 1], results[r0]);

        // Randomized traffic: both requesters, random operands, lengths and backpressure.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && accepted_mask[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && $urandom_range(3) == 0) begin
                    set_ops(i, int'($urandom_range(15)), int'($urandom_range(15)),
                            int'($urandom_range(1)));
                    bus.req_valid[i] = 1'b1;
                end
            end
            bus.len_sel   = 2'($urandom_range(3));
            bus.res_ready = 1'($urandom_range(1));
        end
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        wait_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sc_job_scheduler.md
# sc_job_scheduler

Schedules stochastic-multiply jobs from two requesters onto one shared stochastic stream unit: two LFSRs, two comparators, and a multiply gate. It arbitrates round-robin between requesters and latches the operands and mode. It seeds and runs the stream unit for a selectable bitstream length, counts output ones, and returns the count to the winning requester over a valid/ready handshake. It sits between the tile's input-decoding logic and the binary result path.

## Interface
- `LEN_LOG2_MAX`, default 7: log2 of the longest bitstream (128 bits).
- `SEED_A`, default 31'd1: LFSR-A seed, loaded on every job start.
- `SEED_B`, default 31'd2: LFSR-B seed, loaded on every job start.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-high (asserted = 1).
- `req_valid` in 2: per-requester job request.
- `req_ready` out 2: per-requester accept; one-hot or zero.
- `req_pa0`, `req_pb0` in 4 each: requester-0 operand probabilities, value/16.
- `req_pa1`, `req_pb1` in 4 each: requester-1 operand probabilities, value/16.
- `req_mode` in 2: per requester; 0 = unipolar (AND), 1 = bipolar (XNOR).
- `len_sel` in 2: bitstream length 16 << len_sel (16, 32, 64, 128); sampled at accept.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_count` out LEN_LOG2_MAX+1: number of ones in the output stream, 0..N.
- `res_id` out 1: requester that owns the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → SEED → RUN → DRAIN → DONE → IDLE.
- **IDLE:** if any `req_valid` bit is set, grant one requester.
  - If both are set, grant the one not granted last. The last-grant pointer resets to 1, so requester 0 wins first.
  - `req_ready[g]` is high combinationally for that cycle only.
  - Latch operands, mode, id and N from `len_sel`. Clear the counter. Go to SEED.
- **SEED** (1 cycle): load LFSR-A ← `SEED_A` and LFSR-B ← `SEED_B`. Stream-unit enable stays low. Go to RUN.
- **RUN** (exactly N cycles): stream unit enabled.
  - Comparators: bit = (LFSR top 4 bits < operand).
  - Gate: AND in mode 0, XNOR in mode 1.
  - The down-counter of remaining cycles reaches 0, then go to DRAIN.
- **DRAIN** (2 cycles): flush the comparator and gate register stages. The ones-counter keeps adding valid pipeline bits. A bit is counted only if it entered the pipeline during RUN; the stream unit carries a valid tag alongside the data.
- **DONE:** `res_valid` = 1; `res_count` and `res_id` are stable.
  - Stay until `res_ready` = 1, then go to IDLE.
  - Backpressure is unlimited, and no new grant is issued while in DONE.
- Counter width is LEN_LOG2_MAX+1, so a count of N = 128 never wraps and no overflow flag is needed.
- `req_valid` dropping after the grant has no effect; the job is already latched.
- Both `req_valid` bits set every cycle: grants alternate 0, 1, 0, 1.
- `len_sel` changes during RUN are ignored.

## Timing
- Reset values:
  - `req_ready` = 0, `res_valid` = 0, `res_count` = 0, `res_id` = 0, `busy` = 0.
  - FSM = IDLE, LFSRs = seeds, last-grant = 1.
- Reset asserted mid-job aborts the job at the next edge with no result. The first grant after release follows the reset priority.
- Latency from accept edge to first `res_valid` cycle = 1 (SEED) + N + 2 (DRAIN) + 1 = N + 4 cycles. For N = 16 this is 20.
- Result and ready in the same cycle: the handshake completes and the state is IDLE next cycle. Minimum spacing between accepts is N + 5 cycles.
- `res_count` is registered; `req_ready` is a combinational decode of state and `req_valid`.

## Structure
- Package `sc_pkg`:
  - FSM state enum.
  - Mode constants `MODE_UNI` / `MODE_BI`.
  - LFSR tap positions: A = 30^27, B = 16^12.
  - Function for length decode.
- Sub-module `sc_stream_unit`:
  - Contains both LFSRs with seed-load/enable, comparators, mode gate, and valid tag.
  - 2-stage registered output.
  - Instantiated once.
- The scheduler contains only the arbiter, FSM, cycle and ones counters, and result registers.

## Test plan
- Requester 0 sends pa=0, pb=0, mode=1, `len_sel`=0 → after 20 cycles `res_valid`=1, `res_count`=16 (XNOR of two all-zero streams), `res_id`=0.
- Requester 1 sends pa=0, pb=15, mode=0, `len_sel`=3 → `res_count`=0 at cycle 132, `res_id`=1.
- Both requesters valid continuously, `res_ready` tied 1 → grant order 0, 1, 0, 1, with accept spacing N+5 cycles.
- Hold `res_ready`=0 for 50 cycles in DONE → `res_count` stable, no `req_ready` pulse, and the accept follows the handshake.
- Assert reset during RUN at cycle 10 → next cycle all outputs are at reset values, with no `res_valid`.
- Same job repeated twice (pa=9, pb=5, mode=0, N=64) → identical `res_count` both times, since reseeding makes runs deterministic; the value matches the reference-model LFSR count.
